// File: rtl/dot_product_pkg.sv
// -----------------------------------------------------------------------------
// dot_product_pkg
// Types and helpers shared by the dot-product accumulator and its adder tree.
//   dp_tag_t   : per-stage sideband {valid, first, last} carried down the pipe
//   TAG_IDLE   : empty-stage tag used at reset
//   tree_width : width of the exact sum of M products of two N-bit operands
// -----------------------------------------------------------------------------
package dot_product_pkg;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } dp_tag_t;

  localparam dp_tag_t TAG_IDLE = '{valid: 1'b0, first: 1'b0, last: 1'b0};

  function automatic int tree_width(input int n, input int m);
    return 2 * n + $clog2(m);
  endfunction

endpackage

// File: rtl/dot_product_adder_tree.sv
// -----------------------------------------------------------------------------
// dot_product_adder_tree
// Registered reduction of M lane products into one exact sum (pipeline P2).
// Ports:
//   i_clk, i_reset_n : clock, synchronous active-low reset
//   i_en             : global advance enable; the stage holds when low
//   i_prod           : M products, lane k at [k*2N +: 2N]
//   i_tag            : sideband of the incoming beat
//   o_sum            : registered sum, width tree_width(N, M)
//   o_tag            : registered sideband
// -----------------------------------------------------------------------------
module dot_product_adder_tree
  import dot_product_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 4,
  parameter int SIGNED = 1,
  localparam int TW    = tree_width(N, M)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_en,
  input  logic [M*2*N-1:0]  i_prod,
  input  dp_tag_t           i_tag,
  output logic [TW-1:0]     o_sum,
  output dp_tag_t           o_tag
);

  localparam int PW = 2 * N;

  logic [TW-1:0] w_sum;
  logic [TW-1:0] r_sum;
  dp_tag_t       r_tag;

  // Sum all lanes at full width; each product is extended per the operand mode
  always_comb begin
    w_sum = {TW{1'b0}};
    for (int k = 0; k < M; k++) begin
      if (SIGNED != 32'sd0) begin
        w_sum = w_sum + TW'($signed(i_prod[k*PW +: PW]));
      end else begin
        w_sum = w_sum + TW'(i_prod[k*PW +: PW]);
      end
    end
  end

  // P2 register: advances only with the global enable
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sum <= {TW{1'b0}};
      r_tag <= TAG_IDLE;
    end else if (i_en) begin
      r_sum <= w_sum;
      r_tag <= i_tag;
    end
  end

  assign o_sum = r_sum;
  assign o_tag = r_tag;

endmodule

// File: rtl/dot_product_mxn_acc.sv
// -----------------------------------------------------------------------------
// dot_product_mxn_acc
// Streaming M-lane N-bit dot-product accumulator with saturating S-bit result.
// Pipeline: P0 input reg -> P1 products -> P2 adder tree -> P3 accumulator/out.
// Ports:
//   i_clk, i_reset_n  : clock, synchronous active-low reset
//   i_a, i_b          : M operands each, lane k at [k*N +: N]
//   i_first, i_last   : dot-product framing tags of the beat
//   i_valid / o_ready : input handshake (o_ready is the global advance enable)
//   o_sum, o_overflow : saturated result and sticky saturation flag
//   o_valid / i_ready : output handshake
// -----------------------------------------------------------------------------
module dot_product_mxn_acc
  import dot_product_pkg::*;
#(
  parameter int N      = 8,
  parameter int M      = 4,
  parameter int S      = 48,
  parameter int SIGNED = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [M*N-1:0] i_a,
  input  logic [M*N-1:0] i_b,
  input  logic          i_first,
  input  logic          i_last,
  input  logic          i_valid,
  output logic          o_ready,
  output logic [S-1:0]  o_sum,
  output logic          o_overflow,
  output logic          o_valid,
  input  logic          i_ready
);

  localparam int TW = tree_width(N, M);
  localparam int PW = 2 * N;
  localparam int SX = S + 1;
  localparam logic [S-1:0] SMAX = {1'b0, {(S-1){1'b1}}};
  localparam logic [S-1:0] SMIN = {1'b1, {(S-1){1'b0}}};
  localparam logic [S-1:0] UMAX = {S{1'b1}};

  if ((M < 1) || (S < tree_width(N, M))) begin : g_bad_params
    $error("dot_product_mxn_acc: need M >= 1 and S >= 2*N + $clog2(M)");
  end

  logic            w_en;
  logic [M*N-1:0]  r_p0_a;
  logic [M*N-1:0]  r_p0_b;
  dp_tag_t         r_p0_tag;
  logic [M*PW-1:0] w_prod;
  logic [M*PW-1:0] r_p1_prod;
  dp_tag_t         r_p1_tag;
  logic [TW-1:0]   w_p2_sum;
  dp_tag_t         w_p2_tag;
  logic [SX-1:0]   w_sum_ext;
  logic [SX-1:0]   w_acc_ext;
  logic [SX-1:0]   w_raw;
  logic [S-1:0]    w_acc_next;
  logic            w_sat;
  logic            w_ovf_next;
  logic [S-1:0]    r_acc;
  logic            r_ovf;
  logic [S-1:0]    r_out_sum;
  logic            r_out_ovf;
  logic            r_out_valid;

  // A result the consumer refuses freezes every stage, so nothing is lost
  assign w_en    = ~(r_out_valid & ~i_ready);
  assign o_ready = w_en;

  // P0 input register; a beat is accepted whenever the pipe advances
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_p0_a   <= {(M*N){1'b0}};
      r_p0_b   <= {(M*N){1'b0}};
      r_p0_tag <= TAG_IDLE;
    end else if (w_en) begin
      r_p0_a   <= i_a;
      r_p0_b   <= i_b;
      r_p0_tag <= '{valid: i_valid, first: i_first, last: i_last};
    end
  end

  for (genvar k = 0; k < M; k++) begin : g_lane
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    assign w_a = r_p0_a[k*N +: N];
    assign w_b = r_p0_b[k*N +: N];
    // Operands are widened to the product width first so the 2N-bit product is exact
    if (SIGNED != 32'sd0) begin : g_signed
      assign w_prod[k*PW +: PW] = PW'($signed(w_a)) * PW'($signed(w_b));
    end else begin : g_unsigned
      assign w_prod[k*PW +: PW] = PW'(w_a) * PW'(w_b);
    end
  end

  // P1 product register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_p1_prod <= {(M*PW){1'b0}};
      r_p1_tag  <= TAG_IDLE;
    end else if (w_en) begin
      r_p1_prod <= w_prod;
      r_p1_tag  <= r_p0_tag;
    end
  end

  dot_product_adder_tree #(
    .N      (N),
    .M      (M),
    .SIGNED (SIGNED)
  ) u_tree (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_en      (w_en),
    .i_prod    (r_p1_prod),
    .i_tag     (r_p1_tag),
    .o_sum     (w_p2_sum),
    .o_tag     (w_p2_tag)
  );

  // Next accumulator value: one guard bit above S detects the out-of-range sum
  always_comb begin
    w_sum_ext  = {SX{1'b0}};
    w_acc_ext  = {SX{1'b0}};
    w_raw      = {SX{1'b0}};
    w_acc_next = {S{1'b0}};
    w_sat      = 1'b0;
    w_ovf_next = 1'b0;
    if (SIGNED != 32'sd0) begin
      w_sum_ext = SX'($signed(w_p2_sum));
      w_acc_ext = SX'($signed(r_acc));
    end else begin
      w_sum_ext = SX'(w_p2_sum);
      w_acc_ext = SX'(r_acc);
    end
    if (w_p2_tag.first) begin
      w_raw = w_sum_ext;
    end else begin
      w_raw = w_acc_ext + w_sum_ext;
    end
    if (SIGNED != 32'sd0) begin
      // Signed overflow shows as the guard bit disagreeing with the S-bit sign
      if (w_raw[S] != w_raw[S-1]) begin
        w_sat = 1'b1;
        if (w_raw[S]) begin
          w_acc_next = SMIN;
        end else begin
          w_acc_next = SMAX;
        end
      end else begin
        w_acc_next = w_raw[S-1:0];
      end
    end else begin
      if (w_raw[S]) begin
        w_sat      = 1'b1;
        w_acc_next = UMAX;
      end else begin
        w_acc_next = w_raw[S-1:0];
      end
    end
    if (w_p2_tag.first) begin
      w_ovf_next = w_sat;
    end else begin
      w_ovf_next = r_ovf | w_sat;
    end
  end

  // P3 accumulator and output register; bubbles leave the accumulator alone
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_acc       <= {S{1'b0}};
      r_ovf       <= 1'b0;
      r_out_sum   <= {S{1'b0}};
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      if (w_p2_tag.valid) begin
        r_acc <= w_acc_next;
        r_ovf <= w_ovf_next;
      end
      // With w_en high any held result has just been taken, so valid follows the new beat
      if (w_p2_tag.valid && w_p2_tag.last) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_acc_next;
        r_out_ovf   <= w_ovf_next;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_sum      = r_out_sum;
  assign o_overflow = r_out_ovf;
  assign o_valid    = r_out_valid;

endmodule

// File: tb/tb_dot_product_mxn_acc.sv
module tb_dot_product_mxn_acc;

  // Instance 0: N=8 M=4 S=48 signed; 1: S=18 signed; 2: M=1 unsigned
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic        first_v [3];
  logic        last_v [3];
  logic        valid_v [3];
  logic        iready_v [3];
  wire  [2:0]  rdy;
  wire  [2:0]  ovld;
  wire  [2:0]  ovf;
  wire  [47:0] s0;
  wire  [17:0] s1;
  wire  [47:0] s2;

  int vectors = 0;
  int miscompares = 0;

  dot_product_mxn_acc #(.N(8), .M(4), .S(48), .SIGNED(1)) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a_v[0]), .i_b(b_v[0]),
    .i_first(first_v[0]), .i_last(last_v[0]), .i_valid(valid_v[0]),
    .o_ready(rdy[0]), .o_sum(s0), .o_overflow(ovf[0]), .o_valid(ovld[0]),
    .i_ready(iready_v[0]));

  dot_product_mxn_acc #(.N(8), .M(4), .S(18), .SIGNED(1)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a_v[1]), .i_b(b_v[1]),
    .i_first(first_v[1]), .i_last(last_v[1]), .i_valid(valid_v[1]),
    .o_ready(rdy[1]), .o_sum(s1), .o_overflow(ovf[1]), .o_valid(ovld[1]),
    .i_ready(iready_v[1]));

  dot_product_mxn_acc #(.N(8), .M(1), .S(48), .SIGNED(0)) dut2 (
    .i_clk(clk), .i_reset_n(rst_n), .i_a(a_v[2][7:0]), .i_b(b_v[2][7:0]),
    .i_first(first_v[2]), .i_last(last_v[2]), .i_valid(valid_v[2]),
    .o_ready(rdy[2]), .o_sum(s2), .o_overflow(ovf[2]), .o_valid(ovld[2]),
    .i_ready(iready_v[2]));

  // ---------------- behavioural model ----------------
  typedef struct {
    int          inst;
    logic [47:0] sum;
    bit          ovf;
  } exp_t;

  exp_t   expq[$];
  longint macc [3];
  bit     movf [3];

  function automatic int inst_s(int i);
    return (i == 1) ? 18 : 48;
  endfunction

  function automatic bit inst_signed(int i);
    return (i != 2);
  endfunction

  function automatic int inst_m(int i);
    return (i == 2) ? 1 : 4;
  endfunction

  function automatic logic [47:0] dut_sum(int i);
    case (i)
      0:       return s0;
      1:       return {30'd0, s1};
      default: return s2;
    endcase
  endfunction

  function automatic logic [31:0] l4(int x0, int x1, int x2, int x3);
    return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
  endfunction

  // True mathematical dot product of one beat
  function automatic longint beat_dot(int i, logic [31:0] a, logic [31:0] b);
    longint t = 0;
    longint x;
    longint y;
    logic [7:0] ea;
    logic [7:0] eb;
    for (int k = 0; k < inst_m(i); k++) begin
      ea = a[k*8 +: 8];
      eb = b[k*8 +: 8];
      if (inst_signed(i)) begin
        x = longint'($signed(ea));
        y = longint'($signed(eb));
      end else begin
        x = longint'(ea);
        y = longint'(eb);
      end
      t += x * y;
    end
    return t;
  endfunction

  task automatic model_accept(int i);
    longint d, t, hi, lo, mask;
    int s;
    exp_t e;
    s = inst_s(i);
    d = beat_dot(i, a_v[i], b_v[i]);
    mask = (longint'(1) << s) - 1;
    if (inst_signed(i)) begin
      hi = (longint'(1) << (s - 1)) - 1;
      lo = -(longint'(1) << (s - 1));
    end else begin
      hi = mask;
      lo = 0;
    end
    if (first_v[i]) begin
      t = d;
      movf[i] = 1'b0;
    end else begin
      t = macc[i] + d;
    end
    if (t > hi) begin
      t = hi;
      movf[i] = 1'b1;
    end else if (t < lo) begin
      t = lo;
      movf[i] = 1'b1;
    end
    macc[i] = t;
    if (last_v[i]) begin
      e.inst = i;
      e.sum  = 48'(t & mask);
      e.ovf  = movf[i];
      expq.push_back(e);
    end
  endtask

  // Compare process: runs on every falling edge, inputs are stable here
  always @(negedge clk) begin
    int h;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rdy[i] !== !(ovld[i] && !iready_v[i])) begin
        miscompares++;
        $display("FAIL ready_inst%0d: got %0b, required %0b", i, rdy[i], !(ovld[i] && !iready_v[i]));
      end
      if (ovld[i] === 1'b1) begin
        h = -1;
        for (int j = 0; j < expq.size(); j++) begin
          if (h < 0 && expq[j].inst == i) h = j;
        end
        vectors++;
        if (h < 0) begin
          miscompares++;
          $display("FAIL unexpected_result_inst%0d: got sum=%0d, required no result", i, dut_sum(i));
        end else begin
          if (dut_sum(i) !== expq[h].sum || ovf[i] !== expq[h].ovf) begin
            miscompares++;
            $display("FAIL result_inst%0d: got sum=%0d ovf=%0b, required sum=%0d ovf=%0b",
                     i, dut_sum(i), ovf[i], expq[h].sum, expq[h].ovf);
          end
          if (iready_v[i]) expq.delete(h);
        end
      end
    end
    if (!rst_n) begin
      expq.delete();
      for (int i = 0; i < 3; i++) begin
        macc[i] = 0;
        movf[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (valid_v[i] && rdy[i]) model_accept(i);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(string name, logic [47:0] got, logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(int i, logic [31:0] a, logic [31:0] b, bit f, bit l);
    int g = 0;
    a_v[i] = a;
    b_v[i] = b;
    first_v[i] = f;
    last_v[i] = l;
    valid_v[i] = 1'b1;
    @(negedge clk);
    while (!rdy[i] && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout_inst%0d: got no accept, required accept within 50 cycles", i);
    end
    @(posedge clk);
    #1;
    valid_v[i] = 1'b0;
  endtask

  task automatic expect_res(int i, logic [47:0] es, bit eo, string name);
    int g = 0;
    @(negedge clk);
    while (ovld[i] !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no o_valid, required result %0d", name, es);
    end else begin
      check(name, dut_sum(i), es);
      check({name, "_ovf"}, 48'(ovf[i]), 48'(eo));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_v[i] = 32'd0; b_v[i] = 32'd0;
      first_v[i] = 1'b0; last_v[i] = 1'b0; valid_v[i] = 1'b0;
      iready_v[i] = 1'b1;
      macc[i] = 0; movf[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 48'(ovld), 48'd0);
    check("reset_sum0", s0, 48'd0);
    check("reset_sum1", {30'd0, s1}, 48'd0);
    check("reset_ovf", 48'(ovf), 48'd0);
    check("reset_ready", 48'(rdy), 48'd7);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single beat, latency of exactly three edges
    send(0, l4(1, 2, 3, 4), l4(5, 6, 7, 8), 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("latency", 48'(ovld[0]), (c == 3) ? 48'd1 : 48'd0);
    end
    check("single_beat_sum", s0, 48'd70);
    check("single_beat_ovf", 48'(ovf[0]), 48'd0);
    @(posedge clk);
    #1;

    // three beats of -128 x -128 on all lanes
    for (int k = 0; k < 3; k++)
      send(0, l4(-128, -128, -128, -128), l4(-128, -128, -128, -128), k == 0, k == 2);
    expect_res(0, 48'd196608, 1'b0, "neg128x3");

    // saturation with S=18
    for (int k = 0; k < 2; k++)
      send(1, l4(127, 127, 127, 127), l4(127, 127, 127, 127), k == 0, k == 1);
    expect_res(1, 48'd129032, 1'b0, "sat18_two_beats");
    for (int k = 0; k < 3; k++)
      send(1, l4(127, 127, 127, 127), l4(127, 127, 127, 127), k == 0, k == 2);
    expect_res(1, 48'd131071, 1'b1, "sat18_pos");
    send(1, l4(1, 0, 0, 0), l4(1, 0, 0, 0), 1'b1, 1'b1);
    expect_res(1, 48'd1, 1'b0, "sat18_cleared");
    for (int k = 0; k < 3; k++)
      send(1, l4(-128, -128, -128, -128), l4(127, 127, 127, 127), k == 0, k == 2);
    expect_res(1, 48'd131072, 1'b1, "sat18_neg");

    // backpressure: consumer stalls 5 cycles while 4 single-beat products stream
    fork
      begin
        iready_v[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        iready_v[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_drain", 48'(ovld[0]), 48'd1);
        end
      end
      begin
        for (int k = 0; k < 4; k++)
          send(0, l4(k + 1, k + 2, 1, 0), l4(3, k, 2, 5), 1'b1, 1'b1);
      end
    join
    @(posedge clk);
    #1;

    // restart: a new first discards the open partial sum
    send(0, l4(1, 0, 0, 0), l4(1, 0, 0, 0), 1'b1, 1'b0);
    send(0, l4(2, 0, 0, 0), l4(3, 0, 0, 0), 1'b1, 1'b1);
    expect_res(0, 48'd6, 1'b0, "restart");

    // unsigned single lane
    send(2, 32'd255, 32'd255, 1'b1, 1'b1);
    expect_res(2, 48'd65025, 1'b0, "unsigned_max");

    // reset mid-stream drops everything in flight
    send(0, l4(5, 5, 5, 5), l4(5, 5, 5, 5), 1'b1, 1'b0);
    send(0, l4(7, 7, 7, 7), l4(7, 7, 7, 7), 1'b0, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset_valid", 48'(ovld[0]), 48'd0);
    check("midreset_sum", s0, 48'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("no_stale", 48'(ovld), 48'd0);
    end
    @(posedge clk);
    #1;

    // beat without first after reset accumulates onto zero
    send(2, 32'd2, 32'd3, 1'b0, 1'b1);
    expect_res(2, 48'd6, 1'b0, "nofirst_after_reset");

    repeat (6) @(posedge clk);
    #1;
    check("results_outstanding", 48'(expq.size()), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
